id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter BIT, default 32, datapath width; parameter FW (function width), default `ALU_FUNC_BIT from arith_op.vh.
REQ-002 SHALL have: clk  input  1  sole clock, all state rising-edge.
REQ-003 SHALL have: rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have: flush  input  1  kill held instruction (branch/jump redirect).
REQ-005 SHALL have: in_valid  input  1  decode offers an instruction.
REQ-006 SHALL have: in_ready  output  1  stage accepts the offer this cycle.
REQ-007 SHALL have: in_pc, in_rs1, in_rs2, in_imm  input  BIT each  PC, register-file reads, immediate.
REQ-008 SHALL have: in_rs1_addr, in_rs2_addr, in_rd_addr  input  5 each  source/destination indices.
REQ-009 SHALL have: in_sel  input  2  [0]=1: A from PC else rs1; [1]=1: B from imm else rs2.
REQ-010 SHALL have: in_ALUFunc  input  FW  ALU operation code.
REQ-011 SHALL have: in_ctrl  input  2  [1]=is_load, [0]=rd write enable.
REQ-012 SHALL have: mem_rd_addr  input  5, mem_ctrl  input  2, mem_data  input  BIT  MEM-stage forward source.
REQ-013 SHALL have: wb_rd_addr  input  5, wb_rd_we  input  1, wb_data  input  BIT  WB-stage forward source.
REQ-014 SHALL have: out_valid  output  1  held instruction valid.
REQ-015 SHALL have: out_ready  input  1  downstream accepts held instruction.
REQ-016 SHALL have: dataA, dataB  output  BIT each  ALU operands (forwarded, selected).
REQ-017 SHALL have: ALUFunc  output  FW; out_rd_addr  output  5; out_ctrl  output  2; out_store_data  output  BIT (forwarded rs2).

Function
REQ-018 SHALL hold one instruction in a register slot: pc, rs1, rs2, imm, rs1/rs2/rd addr, sel, ALUFunc, ctrl, valid.
REQ-019 Transfer: capture on edge when in_valid && in_ready; held slot leaves when out_valid && out_ready.
REQ-020 in_ready SHALL = (!out_valid || out_ready) && !hazard, combinational.
REQ-021 hazard SHALL = out_valid && out_ctrl[1] && out_rd_addr!=0 && in_valid && (out_rd_addr==in_rs1_addr || out_rd_addr==in_rs2_addr).
REQ-022 On hazard with out_ready=1: slot becomes a bubble (valid=0) next edge; dependent capture follows one cycle later (exactly one bubble per load-use).
REQ-023 out_valid && !out_ready SHALL hold all slot fields unchanged (forwarded operands still track mem/wb).
REQ-024 flush SHALL clear valid next edge, priority over capture and hold; payload fields may keep stale values.
REQ-025 Forwarded rsN = mem_data if mem_ctrl[0] && !mem_ctrl[1] && mem_rd_addr==addrN && addrN!=0; else wb_data if wb_rd_we && wb_rd_addr==addrN && addrN!=0; else registered rsN. MEM beats WB.
REQ-026 dataA = sel[0] ? pc : fwd rs1; dataB = sel[1] ? imm : fwd rs2; out_store_data = fwd rs2 regardless of sel[1].
REQ-027 Forwarding/select SHALL be combinational from slot + mem/wb ports; zero-cycle latency slot-to-operand.
REQ-028 Outputs SHALL be computed when out_valid=0; consumers gate on out_valid.
REQ-029 out_ctrl SHALL read 2'b00 when out_valid=0 (no spurious write/load downstream).

Reset
REQ-030 rst_n low SHALL immediately clear valid and every slot field to 0 (dataA=dataB=0, ALUFunc=0, out_rd_addr=0, out_ctrl=0), independent of clk.
REQ-031 rst_n low mid-stall/mid-hazard SHALL drop held instruction; first edge after release with in_valid=1 captures.

Verification
REQ-032 Plain flow: in_rs1=5, in_rs2=7, sel=0, in_valid=1, out_ready=1 -> next cycle out_valid=1, dataA=5, dataB=7.
REQ-033 Forward priority: slot rs1_addr=3, mem rd=3 we=1 data=0x11, wb rd=3 data=0x22 -> dataA=0x11; mem_ctrl=0 -> dataA=0x22; rs1_addr=0 -> no forward.
REQ-034 Load-use: slot load rd=4, in_rs2_addr=4 -> in_ready=0 one cycle, bubble (out_valid=0) one cycle, then dependent held with wb rd=4 forwarding wb_data.
REQ-035 Backpressure: out_ready=0 for 3 cycles -> in_ready=0, slot unchanged; release -> next instruction captured same edge.
REQ-036 Flush with simultaneous in_valid -> out_valid=0 next cycle, no capture; reset asserted during stall -> all outputs 0 within same cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline slot: holds one decoded instruction, stalls on load-use,
// and presents forwarded, source-selected ALU operands combinationally.
`ifndef ALU_FUNC_BIT
`define ALU_FUNC_BIT 4
`endif

module id_ex_stage #(
  parameter int BIT = 32,
  parameter int FW  = `ALU_FUNC_BIT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [BIT-1:0] in_pc,
  input  logic [BIT-1:0] in_rs1,
  input  logic [BIT-1:0] in_rs2,
  input  logic [BIT-1:0] in_imm,
  input  logic [4:0]     in_rs1_addr,
  input  logic [4:0]     in_rs2_addr,
  input  logic [4:0]     in_rd_addr,
  input  logic [1:0]     in_sel,
  input  logic [FW-1:0]  in_ALUFunc,
  input  logic [1:0]     in_ctrl,
  input  logic [4:0]     mem_rd_addr,
  input  logic [1:0]     mem_ctrl,
  input  logic [BIT-1:0] mem_data,
  input  logic [4:0]     wb_rd_addr,
  input  logic           wb_rd_we,
  input  logic [BIT-1:0] wb_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BIT-1:0] dataA,
  output logic [BIT-1:0] dataB,
  output logic [FW-1:0]  ALUFunc,
  output logic [4:0]     out_rd_addr,
  output logic [1:0]     out_ctrl,
  output logic [BIT-1:0] out_store_data
);

  logic           valid_q, valid_d;
  logic [BIT-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [4:0]     rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
  logic [1:0]     sel_q, sel_d, ctrl_q, ctrl_d;
  logic [FW-1:0]  func_q, func_d;
  logic           hazard;
  logic [BIT-1:0] fwd_rs1, fwd_rs2;

  // A load in the slot cannot feed the instruction behind it without one bubble.
  assign hazard = valid_q && ctrl_q[1] && (rd_addr_q != 5'd0) && in_valid &&
                  ((rd_addr_q == in_rs1_addr) || (rd_addr_q == in_rs2_addr));
  assign in_ready = (!valid_q || out_ready) && !hazard;

  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    imm_d      = imm_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    sel_d      = sel_q;
    ctrl_d     = ctrl_q;
    func_d     = func_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d    = 1'b1;
      pc_d       = in_pc;
      rs1_d      = in_rs1;
      rs2_d      = in_rs2;
      imm_d      = in_imm;
      rs1_addr_d = in_rs1_addr;
      rs2_addr_d = in_rs2_addr;
      rd_addr_d  = in_rd_addr;
      sel_d      = in_sel;
      ctrl_d     = in_ctrl;
      func_d     = in_ALUFunc;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      sel_q      <= '0;
      ctrl_q     <= '0;
      func_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      sel_q      <= sel_d;
      ctrl_q     <= ctrl_d;
      func_q     <= func_d;
    end
  end

  // MEM result wins over WB; a load in MEM has no data yet, so it never forwards.
  function automatic logic [BIT-1:0] forward(input logic [4:0] addr, input logic [BIT-1:0] reg_val);
    logic [BIT-1:0] r;
    r = reg_val;
    if (addr != 5'd0) begin
      if (mem_ctrl[0] && !mem_ctrl[1] && (mem_rd_addr == addr))
        r = mem_data;
      else if (wb_rd_we && (wb_rd_addr == addr))
        r = wb_data;
    end
    return r;
  endfunction

  always_comb begin
    fwd_rs1 = forward(rs1_addr_q, rs1_q);
    fwd_rs2 = forward(rs2_addr_q, rs2_q);
  end

  assign out_valid      = valid_q;
  assign dataA          = sel_q[0] ? pc_q : fwd_rs1;
  assign dataB          = sel_q[1] ? imm_q : fwd_rs2;
  assign out_store_data = fwd_rs2;
  assign ALUFunc        = func_q;
  assign out_rd_addr    = rd_addr_q;
  assign out_ctrl       = valid_q ? ctrl_q : 2'b00;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/reset cases plus a random
// stream checked against a transaction scoreboard.
module tb_id_ex_stage;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [31:0]   in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
  logic [4:0]    in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
  logic [1:0]    in_sel = '0, in_ctrl = '0;
  logic [FW-1:0] in_ALUFunc = '0;
  logic [4:0]    mem_rd_addr = '0, wb_rd_addr = '0;
  logic [1:0]    mem_ctrl = '0;
  logic [31:0]   mem_data = '0, wb_data = '0;
  logic          wb_rd_we = 1'b0;
  logic          out_valid, out_ready = 1'b1;
  logic [31:0]   dataA, dataB, out_store_data;
  logic [FW-1:0] ALUFunc;
  logic [4:0]    out_rd_addr;
  logic [1:0]    out_ctrl;

  id_ex_stage #(.BIT(32), .FW(FW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_sel(in_sel), .in_ALUFunc(in_ALUFunc), .in_ctrl(in_ctrl),
    .mem_rd_addr(mem_rd_addr), .mem_ctrl(mem_ctrl), .mem_data(mem_data),
    .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .dataA(dataA), .dataB(dataB),
    .ALUFunc(ALUFunc), .out_rd_addr(out_rd_addr), .out_ctrl(out_ctrl),
    .out_store_data(out_store_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   pc, rs1, rs2, imm;
    logic [4:0]    a1, a2, rd;
    logic [1:0]    sel, ctrl;
    logic [FW-1:0] func;
  } txn_t;

  txn_t sb[$];
  txn_t cur, got;
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference forwarding: the newest producer of a nonzero register supplies its value.
  function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] v);
    if (a == 5'd0) return v;
    if (mem_ctrl == 2'b01 && mem_rd_addr == a) return mem_data;
    if (wb_rd_we && wb_rd_addr == a) return wb_data;
    return v;
  endfunction

  task automatic drive(input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] a1, a2, rd,
                       input logic [1:0] sel, ctrl, input logic [FW-1:0] func);
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_rs1_addr = a1; in_rs2_addr = a2; in_rd_addr = rd;
    in_sel = sel; in_ctrl = ctrl; in_ALUFunc = func; in_valid = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accepted offer, pop and compare when downstream takes the slot.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
          got = sb.pop_front();
          check_eq("sb_dataA", dataA, got.sel[0] ? got.pc : model_fwd(got.a1, got.rs1));
          check_eq("sb_dataB", dataB, got.sel[1] ? got.imm : model_fwd(got.a2, got.rs2));
          check_eq("sb_store", out_store_data, model_fwd(got.a2, got.rs2));
          check_eq("sb_func", 32'(ALUFunc), 32'(got.func));
          check_eq("sb_rd", 32'(out_rd_addr), 32'(got.rd));
          check_eq("sb_ctrl", 32'(out_ctrl), 32'(got.ctrl));
          $display("txn rd=%0d ctrl=%0d A=%08h B=%08h st=%08h", out_rd_addr, out_ctrl, dataA, dataB, out_store_data);
        end
      end else if (flush && out_valid && sb.size() > 0) begin
        void'(sb.pop_front());
      end
      if (in_valid && in_ready && !flush) begin
        cur.pc = in_pc; cur.rs1 = in_rs1; cur.rs2 = in_rs2; cur.imm = in_imm;
        cur.a1 = in_rs1_addr; cur.a2 = in_rs2_addr; cur.rd = in_rd_addr;
        cur.sel = in_sel; cur.ctrl = in_ctrl; cur.func = in_ALUFunc;
        sb.push_back(cur);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic accepted;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_dataA", dataA, 32'd0);
    check_eq("rst_dataB", dataB, 32'd0);
    check_eq("rst_ctrl", 32'(out_ctrl), 32'd0);
    check_eq("rst_func", 32'(ALUFunc), 32'd0);
    check_eq("rst_rd", 32'(out_rd_addr), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    cyc(); cyc();
    rst_n = 1'b1;

    // plain flow
    drive(32'h0, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd9, 2'b00, 2'b01, 4'd3);
    #1 check_eq("plain_in_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    check_eq("plain_valid", 32'(out_valid), 32'd1);
    check_eq("plain_dataA", dataA, 32'd5);
    check_eq("plain_dataB", dataB, 32'd7);
    check_eq("plain_ctrl", 32'(out_ctrl), 32'd1);
    cyc();
    check_eq("empty_valid", 32'(out_valid), 32'd0);
    check_eq("empty_ctrl", 32'(out_ctrl), 32'd0);

    // pc / imm selection
    drive(32'h100, 32'h1, 32'h33, 32'h40, 5'd1, 5'd2, 5'd3, 2'b11, 2'b00, 4'd5);
    cyc();
    in_valid = 1'b0;
    check_eq("sel_dataA", dataA, 32'h100);
    check_eq("sel_dataB", dataB, 32'h40);
    check_eq("sel_store", out_store_data, 32'h33);
    cyc();

    // forwarding priority on a held instruction
    out_ready = 1'b0;
    drive(32'h0, 32'h99, 32'h5, 32'h0, 5'd3, 5'd6, 5'd7, 2'b00, 2'b01, 4'd1);
    cyc();
    in_valid = 1'b0;
    mem_rd_addr = 5'd3; mem_ctrl = 2'b01; mem_data = 32'h11;
    wb_rd_addr = 5'd3; wb_rd_we = 1'b1; wb_data = 32'h22;
    #1 check_eq("fwd_mem_first", dataA, 32'h11);
    mem_ctrl = 2'b00;
    #1 check_eq("fwd_wb", dataA, 32'h22);
    mem_ctrl = 2'b11; wb_rd_we = 1'b0;
    #1 check_eq("fwd_load_none", dataA, 32'h99);
    mem_ctrl = 2'b00; out_ready = 1'b1;
    cyc();

    // register zero is never forwarded
    mem_rd_addr = 5'd0; mem_ctrl = 2'b01; mem_data = 32'h77;
    wb_rd_addr = 5'd0; wb_rd_we = 1'b1; wb_data = 32'h66;
    drive(32'h0, 32'h55, 32'h44, 32'h0, 5'd0, 5'd0, 5'd1, 2'b00, 2'b01, 4'd2);
    cyc();
    in_valid = 1'b0;
    check_eq("fwd_x0_A", dataA, 32'h55);
    check_eq("fwd_x0_B", dataB, 32'h44);
    cyc();
    mem_ctrl = 2'b00; wb_rd_we = 1'b0;

    // load-use: one stall, one bubble, then dependent with WB forwarding
    drive(32'h0, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd4, 2'b00, 2'b11, 4'd0);
    cyc();
    drive(32'h0, 32'h10, 32'hDEAD, 32'h0, 5'd5, 5'd4, 5'd6, 2'b00, 2'b01, 4'd2);
    #1 check_eq("lu_in_ready", 32'(in_ready), 32'd0);
    cyc();
    check_eq("lu_bubble", 32'(out_valid), 32'd0);
    check_eq("lu_ready_after", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    check_eq("lu_dep_valid", 32'(out_valid), 32'd1);
    wb_rd_addr = 5'd4; wb_rd_we = 1'b1; wb_data = 32'hCAFE;
    #1;
    check_eq("lu_store_fwd", out_store_data, 32'hCAFE);
    check_eq("lu_dataB_fwd", dataB, 32'hCAFE);
    check_eq("lu_dataA", dataA, 32'h10);
    cyc();
    wb_rd_we = 1'b0;

    // a load to x0 never stalls
    drive(32'h0, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd0, 2'b00, 2'b11, 4'd0);
    cyc();
    drive(32'h0, 32'h3, 32'h4, 32'h0, 5'd0, 5'd0, 5'd2, 2'b00, 2'b01, 4'd1);
    #1 check_eq("lu_rd0_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    cyc();

    // backpressure
    drive(32'h0, 32'hA1, 32'hA2, 32'h0, 5'd8, 5'd9, 5'd10, 2'b00, 2'b01, 4'd6);
    cyc();
    out_ready = 1'b0;
    drive(32'h0, 32'hB1, 32'hB2, 32'h0, 5'd11, 5'd12, 5'd13, 2'b00, 2'b01, 4'd7);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_hold_A", dataA, 32'hA1);
      check_eq("bp_hold_rd", 32'(out_rd_addr), 32'd10);
      cyc();
    end
    out_ready = 1'b1;
    #1 check_eq("bp_release_ready", 32'(in_ready), 32'd1);
    cyc();
    in_valid = 1'b0;
    check_eq("bp_next_valid", 32'(out_valid), 32'd1);
    check_eq("bp_next_A", dataA, 32'hB1);
    cyc();

    // flush beats a simultaneous capture
    out_ready = 1'b0;
    drive(32'h0, 32'hC1, 32'hC2, 32'h0, 5'd14, 5'd15, 5'd16, 2'b00, 2'b01, 4'd1);
    cyc();
    drive(32'h0, 32'hD1, 32'hD2, 32'h0, 5'd17, 5'd18, 5'd19, 2'b00, 2'b01, 4'd2);
    flush = 1'b1; out_ready = 1'b1;
    #1 check_eq("fl_in_ready", 32'(in_ready), 32'd1);
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("fl_no_capture", 32'(out_valid), 32'd0);
    check_eq("fl_ctrl", 32'(out_ctrl), 32'd0);
    // flush beats hold
    out_ready = 1'b0;
    drive(32'h0, 32'hE1, 32'hE2, 32'h0, 5'd20, 5'd21, 5'd22, 2'b00, 2'b01, 4'd3);
    cyc();
    in_valid = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
    check_eq("fl_hold_killed", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    cyc();

    // reset mid-stall
    out_ready = 1'b0;
    drive(32'hF0, 32'hF1, 32'hF2, 32'hF3, 5'd17, 5'd18, 5'd19, 2'b01, 2'b01, 4'd7);
    cyc();
    drive(32'h0, 32'h61, 32'h62, 32'h0, 5'd20, 5'd21, 5'd22, 2'b00, 2'b01, 4'd4);
    #1 check_eq("rs_stalled", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_eq("rs_valid", 32'(out_valid), 32'd0);
    check_eq("rs_dataA", dataA, 32'd0);
    check_eq("rs_dataB", dataB, 32'd0);
    check_eq("rs_store", out_store_data, 32'd0);
    check_eq("rs_ctrl", 32'(out_ctrl), 32'd0);
    check_eq("rs_rd", 32'(out_rd_addr), 32'd0);
    check_eq("rs_func", 32'(ALUFunc), 32'd0);
    cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    check_eq("rs_capture_valid", 32'(out_valid), 32'd1);
    check_eq("rs_capture_A", dataA, 32'h61);
    cyc();

    // random stream with backpressure, hazards and forwarding
    for (int n = 0; n < 24; n++) begin
      drive($urandom, $urandom, $urandom, $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), FW'($urandom_range(0, 15)));
      accepted = 1'b0;
      for (int k = 0; k < 16 && !accepted; k++) begin
        out_ready   = ($urandom_range(0, 3) != 0);
        mem_rd_addr = 5'($urandom_range(0, 7));
        mem_ctrl    = 2'($urandom_range(0, 3));
        mem_data    = $urandom;
        wb_rd_addr  = 5'($urandom_range(0, 7));
        wb_rd_we    = 1'($urandom_range(0, 1));
        wb_data     = $urandom;
        #1 accepted = in_ready;
        cyc();
      end
      if (!accepted) check_eq("rand_accept", 32'd0, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1; mem_ctrl = 2'b00; wb_rd_we = 1'b0;
    repeat (3) cyc();
    check_eq("sb_drain", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
